// File: rtl/mul_pkg.sv
// Shared types and constants for the shift-and-add multiplier sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mul_pkg;

  localparam int MUL_W     = 64;
  localparam int MUL_ITERS = 64;
  localparam int MUL_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mul_state_t;

endpackage

// File: rtl/mul_sequencer_if.sv
// Request/response bundle between a multiply issuer and mul_sequencer.
// Latency: n/a (wires only).
// Backpressure: req_ready gates requests, rsp_ready holds the response.
interface mul_sequencer_if;

  logic                       req_valid;
  logic                       req_ready;
  logic [mul_pkg::MUL_W-1:0]  req_a;
  logic [mul_pkg::MUL_W-1:0]  req_b;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [mul_pkg::MUL_W-1:0]  rsp_product;
  logic                       busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_product, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_product, busy
  );

endinterface

// File: rtl/ADD.sv
// 64-bit ripple-carry adder; carry out of the top bit is dropped (mod 2^64).
// Latency: combinational.
// Backpressure: none.
module ADD
  import mul_pkg::*;
(
  input  logic [MUL_W-1:0] a_i,
  input  logic [MUL_W-1:0] b_i,
  output logic [MUL_W-1:0] y_o
);

  logic carry;

  // Bit-serial ripple chain from LSB to MSB.
  always_comb begin
    carry = 1'b0;
    y_o   = '0;
    for (int i = 0; i < MUL_W; i++) begin
      y_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry  = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// Sequences one ADD instance over 64 shift-and-add steps to form low 64 bits of A*B.
// Latency: 64 cycles accept-to-valid, fixed; one op in flight.
// Backpressure: product held in DONE until rsp_ready; req_ready only in IDLE.
module mul_sequencer
  import mul_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mul_sequencer_if.slave bus
);

  localparam logic [MUL_CNT_W-1:0] LAST_STEP = MUL_CNT_W'(MUL_ITERS - 1);

  mul_state_t           state_q, state_d;
  logic [MUL_W-1:0]     acc_q, acc_d;
  logic [MUL_W-1:0]     mcand_q, mcand_d;
  logic [MUL_W-1:0]     mplier_q, mplier_d;
  logic [MUL_CNT_W-1:0] cnt_q, cnt_d;
  logic [MUL_W-1:0]     sum;

  // The only arithmetic in the datapath: acc + shifted multiplicand.
  ADD u_add (
    .a_i (acc_q),
    .b_i (mcand_q),
    .y_o (sum)
  );

  // State and datapath registers; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and datapath update; everything holds unless a state acts on it.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        // req_ready is implied by being in IDLE.
        if (bus.req_valid) begin
          acc_d    = '0;
          mcand_d  = bus.req_a;
          mplier_d = bus.req_b;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (mplier_q[0]) acc_d = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) state_d = DONE;
      end
      DONE: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.rsp_valid   = (state_q == DONE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.rsp_product = acc_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Randomized + directed bench for mul_sequencer with queue-based scoreboard.
// Latency: expects 64-cycle accept-to-valid and one op in flight.
// Backpressure: varies rsp_ready delay; checks hold and re-accept timing.
`timescale 1ns/1ps
module tb_mul_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  int n_vec = 0;
  int n_err = 0;

  mul_sequencer_if bus ();

  mul_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state: expected products and their accept edges.
  logic [63:0] exp_q[$];
  int          edge_q[$];
  bit          started   = 1'b0;
  bit          after_rst = 1'b0;
  bit          b2b_armed = 1'b0;
  int          b2b_edge  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Monitor: compares DUT outputs against the in-flight model each cycle.
  always @(negedge clk) begin
    bit exp_busy, exp_rv;
    if (started) begin
      exp_busy = (exp_q.size() != 0);
      exp_rv   = exp_busy && (cyc >= edge_q[0] + 64);
      chk("req_ready", {63'd0, bus.req_ready}, {63'd0, !exp_busy});
      chk("busy",      {63'd0, bus.busy},      {63'd0, exp_busy});
      chk("rsp_valid", {63'd0, bus.rsp_valid}, {63'd0, exp_rv});
      if (exp_rv) chk("rsp_product", bus.rsp_product, exp_q[0]);
      if (after_rst) begin
        chk("product_after_reset", bus.rsp_product, 64'd0);
        after_rst = 1'b0;
      end
    end
    if (rst) begin
      exp_q.delete();
      edge_q.delete();
      b2b_armed = 1'b0;
      started   = 1'b1;
      after_rst = 1'b1;
    end else if (started) begin
      if (bus.rsp_valid && bus.rsp_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        void'(edge_q.pop_front());
        if (bus.req_valid) begin
          b2b_armed = 1'b1;
          b2b_edge  = cyc + 2;
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        exp_q.push_back(bus.req_a * bus.req_b);
        edge_q.push_back(cyc + 1);
        if (b2b_armed) begin
          chk("b2b_accept_edge", 64'(cyc + 1), 64'(b2b_edge));
          b2b_armed = 1'b0;
        end
      end
    end
  end

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s timeout @cyc %0d: got no event, expected one within 300 cycles", name, cyc);
  endtask

  task automatic wait_accept();
    int n;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus.req_ready && !rst) break;
    end
    if (n == 300) timeout("accept");
    @(posedge clk);
    #1;
  endtask

  task automatic take_rsp(input int bp, input bit toggle);
    int n;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus.rsp_valid) break;
      if (toggle) begin
        bus.req_a = rnd64();
        bus.req_b = rnd64();
      end
    end
    if (n == 300) timeout("rsp_valid");
    if (bp > 0) begin
      repeat (bp) @(posedge clk);
      #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic op(input logic [63:0] a, input logic [63:0] b, input int bp, input bit toggle);
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    wait_accept();
    bus.req_valid = 1'b0;
    take_rsp(bp, toggle);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Directed products, including signed and zero cases.
    op(64'd3, 64'd5, 0, 1'b0);
    op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1, 1'b0);
    op(64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 0, 1'b0);
    op(64'd0, 64'h1234_5678_9ABC_DEF0, 2, 1'b0);

    // Ten cycles of backpressure in DONE.
    op(64'd11, 64'd13, 10, 1'b0);

    // Back-to-back: request stays valid with new operands through DONE.
    bus.req_valid = 1'b1;
    bus.req_a     = 64'd3;
    bus.req_b     = 64'd5;
    wait_accept();
    bus.req_a     = 64'h10;
    bus.req_b     = 64'h10;
    take_rsp(3, 1'b0);
    wait_accept();
    bus.req_valid = 1'b0;
    take_rsp(0, 1'b0);

    // Abort mid-RUN with reset, then a fresh op.
    bus.req_valid = 1'b1;
    bus.req_a     = 64'd1234;
    bus.req_b     = 64'd5678;
    wait_accept();
    bus.req_valid = 1'b0;
    repeat (29) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_req_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("abort_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("abort_busy",      {63'd0, bus.busy},      64'd0);
    @(posedge clk);
    #1;
    op(64'd6, 64'd7, 0, 1'b0);

    // Request coincident with reset must not be accepted.
    bus.req_valid = 1'b1;
    bus.req_a     = 64'd99;
    bus.req_b     = 64'd99;
    rst           = 1'b1;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rst_req_busy", {63'd0, bus.busy}, 64'd0);
    @(posedge clk);
    #1;

    // Operands toggled while the op is running.
    op(64'd9, 64'd9, 0, 1'b1);

    // Random operands, backpressure and operand churn.
    for (int i = 0; i < 12; i++) begin
      op(rnd64(), rnd64(), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("final_idle", {63'd0, bus.req_ready}, 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
